// File: rtl/keccak_pi_stream.sv
// Streaming Keccak pi-step engine: permutes one 25-bit slice over 25/STEP cycles.
// Optional macro INVERSE_PI_EN adds an `inverse` input selecting the inverse mapping.
module keccak_pi_stream #(
  parameter int STEP     = 1,
  parameter int NUM_PAGE = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [24:0]                 in_data,
`ifdef INVERSE_PI_EN
  input  logic                        inverse,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [24:0]                 out_data,
  output logic [$clog2(NUM_PAGE)-1:0] page_idx,
  output logic                        frame_done
);

  localparam int PW = $clog2(NUM_PAGE);

  typedef enum logic [1:0] {IDLE, PERM, EMIT} state_e;

  state_e        state_q;
  logic [24:0]   src_q;
  logic [24:0]   out_data_q;
  logic [24:0]   perm_d;
  logic [4:0]    cnt_q;
  logic [PW-1:0] page_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          frame_done_q;
`ifdef INVERSE_PI_EN
  logic          inv_q;
`endif

  if (!(STEP == 1 || STEP == 5 || STEP == 25)) begin : g_bad_step
    $error("keccak_pi_stream: STEP must be 1, 5 or 25");
  end
  if (NUM_PAGE < 2) begin : g_bad_pages
    $error("keccak_pi_stream: NUM_PAGE must be at least 2");
  end

  // Forward pi destination of bit x+5y: y + 5*((2x+3y) mod 5).
  function automatic logic [4:0] piMap(input logic [4:0] i);
    logic [2:0] x;
    logic [2:0] y;
    logic [2:0] z;
    logic [4:0] t;
    x = 3'(i % 5'd5);
    y = 3'(i / 5'd5);
    t = {1'b0, x, 1'b0} + {2'b00, y} + {1'b0, y, 1'b0};
    z = 3'(t % 5'd5);
    return {2'b00, y} + ({2'b00, z} * 5'd5);
  endfunction

  always_comb begin
    logic [4:0] idx;
    idx    = '0;
    perm_d = out_data_q;
    for (int k = 0; k < STEP; k++) begin
      idx = cnt_q + 5'(k);
      if (idx < 5'd25) begin
`ifdef INVERSE_PI_EN
        if (inv_q) perm_d[idx] = src_q[piMap(idx)];
        else       perm_d[piMap(idx)] = src_q[idx];
`else
        perm_d[piMap(idx)] = src_q[idx];
`endif
      end
    end
  end

  // The extra PERM cycle at cnt==25 gives the 25/STEP+1 input-to-output latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      src_q        <= '0;
      out_data_q   <= '0;
      cnt_q        <= '0;
      page_q       <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef INVERSE_PI_EN
      inv_q        <= 1'b0;
`endif
    end else if (clear) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      page_q       <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            src_q      <= in_data;
            out_data_q <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= PERM;
`ifdef INVERSE_PI_EN
            inv_q      <= inverse;
`endif
          end
        end
        PERM: begin
          if (cnt_q == 5'd25) begin
            out_valid_q <= 1'b1;
            state_q     <= EMIT;
          end else begin
            out_data_q <= perm_d;
            cnt_q      <= cnt_q + 5'(STEP);
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
            if (page_q == PW'(NUM_PAGE - 1)) begin
              page_q       <= '0;
              frame_done_q <= 1'b1;
            end else begin
              page_q <= page_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign page_idx   = page_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_keccak_pi_stream.sv
// Scoreboard bench for keccak_pi_stream: three lanes (STEP 1, 5, 25) with NUM_PAGE=4.
// Drivers push expected slices into per-lane queues; per-lane monitors pop on output handshakes.
module tb_keccak_pi_stream;

  localparam int NP = 4;
  // Hand-derived forward pi destination of each source bit x+5y.
  localparam int DST[25] = '{0, 10, 20, 5, 15, 16, 1, 11, 21, 6, 7, 17, 2, 12, 22,
                             23, 8, 18, 3, 13, 14, 24, 9, 19, 4};
  localparam int LAT[3] = '{26, 6, 2};

  logic        clk = 1'b0;
  logic        rst;
  logic        clear[3];
  logic        inValid[3];
  logic        inReady[3];
  logic [24:0] inData[3];
  logic        invSel[3];
  logic        outValid[3];
  logic        outReady[3];
  logic [24:0] outData[3];
  logic [1:0]  pageIdx[3];
  logic        frameDone[3];

  logic [24:0] expQ[3][$];
  int          expPage[3];
  logic        pendFd[3];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gLane
    localparam int S = (g == 0) ? 1 : ((g == 1) ? 5 : 25);

    keccak_pi_stream #(.STEP(S), .NUM_PAGE(NP)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear[g]),
      .in_valid   (inValid[g]),
      .in_ready   (inReady[g]),
      .in_data    (inData[g]),
`ifdef INVERSE_PI_EN
      .inverse    (invSel[g]),
`endif
      .out_valid  (outValid[g]),
      .out_ready  (outReady[g]),
      .out_data   (outData[g]),
      .page_idx   (pageIdx[g]),
      .frame_done (frameDone[g])
    );

    // Monitor samples mid-cycle, after the driver has settled this cycle's inputs.
    always begin
      @(negedge clk);
      #3;
      if (rst) begin
        checkOutput("frame_done", g, 32'(frameDone[g]), 32'(pendFd[g]));
        pendFd[g] = 1'b0;
        if (outValid[g] && outReady[g] && !clear[g]) begin
          if (expQ[g].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output lane %0d actual=%0h required=none", g, outData[g]);
          end else begin
            checkOutput("out_data", g, 32'(outData[g]), 32'(expQ[g].pop_front()));
          end
          checkOutput("page_idx", g, 32'(pageIdx[g]), 32'(expPage[g]));
          pendFd[g]  = (expPage[g] == NP - 1);
          expPage[g] = (expPage[g] + 1) % NP;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int lane,
                             input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s lane %0d actual=%0h required=%0h", name, lane, act, req);
    end
  endtask

  function automatic logic [24:0] refPi(input logic [24:0] d);
    logic [24:0] r;
    r = '0;
    for (int i = 0; i < 25; i++) r[DST[i]] = d[i];
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic checkIdle(input int g);
    checkOutput("idle_in_ready", g, 32'(inReady[g]), 32'd1);
    checkOutput("idle_out_valid", g, 32'(outValid[g]), 32'd0);
    checkOutput("idle_page_idx", g, 32'(pageIdx[g]), 32'd0);
    checkOutput("idle_frame_done", g, 32'(frameDone[g]), 32'd0);
  endtask

  task automatic resetModel();
    for (int g = 0; g < 3; g++) begin
      expQ[g].delete();
      expPage[g] = 0;
      pendFd[g]  = 1'b0;
    end
  endtask

  // Issue one slice, queue its expectation, and measure cycles until out_valid.
  task automatic applyStimulus(input int g, input logic [24:0] d, input logic [24:0] exp);
    int n;
    n = 0;
    while (!inReady[g] && n < 100) begin
      step();
      n++;
    end
    checkOutput("in_ready_wait", g, 32'(inReady[g]), 32'd1);
    inValid[g] = 1'b1;
    inData[g]  = d;
    step();
    expQ[g].push_back(exp);
    inValid[g] = 1'b0;
    inData[g]  = 25'($urandom);
    n = 0;
    while (!outValid[g] && n < 100) begin
      step();
      n++;
    end
    checkOutput("latency", g, 32'(n), 32'(LAT[g]));
  endtask

  initial begin
    logic [24:0] d;
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      clear[g]    = 1'b0;
      inValid[g]  = 1'b0;
      inData[g]   = '0;
      invSel[g]   = 1'b0;
      outReady[g] = 1'b1;
    end
    resetModel();
    repeat (3) step();
    for (int g = 0; g < 3; g++) begin
      checkIdle(g);
      checkOutput("reset_out_data", g, 32'(outData[g]), 32'd0);
    end
    rst = 1'b1;
    step();

    // Lane 0 (STEP=1): directed single-bit vectors, one full frame.
    applyStimulus(0, 25'h0000001, 25'h0000001);
    applyStimulus(0, 25'h0000002, 25'h0000400);
    applyStimulus(0, 25'h0000020, 25'h0010000);
    applyStimulus(0, 25'h1000000, 25'h0000010);

    // Lane 1 (STEP=5): directed patterns plus table-model random slices.
    applyStimulus(1, 25'h1FFFFFF, 25'h1FFFFFF);
    applyStimulus(1, 25'h0000018, 25'h0008020);
    for (int i = 0; i < 3; i++) begin
      d = 25'($urandom);
      applyStimulus(1, d, refPi(d));
    end

    // Lane 2 (STEP=25): random slices against the table model.
    applyStimulus(2, 25'h0000002, 25'h0000400);
    for (int i = 0; i < 4; i++) begin
      d = 25'($urandom);
      applyStimulus(2, d, refPi(d));
    end

    // Backpressure on lane 1: output held for 10 cycles, then exactly one handshake.
    outReady[1] = 1'b0;
    d = 25'h0ABCDEF;
    applyStimulus(1, d, refPi(d));
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("hold_out_data", 1, 32'(outData[1]), 32'(refPi(d)));
      checkOutput("hold_out_valid", 1, 32'(outValid[1]), 32'd1);
      checkOutput("hold_in_ready", 1, 32'(inReady[1]), 32'd0);
    end
    outReady[1] = 1'b1;
    step();
    checkOutput("release_out_valid", 1, 32'(outValid[1]), 32'd0);
    checkOutput("release_in_ready", 1, 32'(inReady[1]), 32'd1);
    repeat (3) step();

`ifdef INVERSE_PI_EN
    invSel[0] = 1'b1;
    applyStimulus(0, 25'h0000400, 25'h0000002);
    d = 25'($urandom);
    applyStimulus(0, refPi(d), d);
    invSel[0] = 1'b0;
`endif

    // Async reset while lane 0 is mid-PERM on an all-ones slice with page_idx nonzero.
    applyStimulus(0, 25'h0000003, 25'h0000401);
    repeat (3) step();
    inValid[0] = 1'b1;
    inData[0]  = 25'h1FFFFFF;
    step();
    inValid[0] = 1'b0;
    repeat (5) step();
    rst = 1'b0;
    #1;
    resetModel();
    for (int g = 0; g < 3; g++) begin
      checkIdle(g);
      checkOutput("rst_out_data", g, 32'(outData[g]), 32'd0);
    end
    step();
    rst = 1'b1;
    step();
    applyStimulus(0, 25'h0000020, 25'h0010000);
    repeat (3) step();

    // Clear during EMIT of lane 2's last page with out_ready high: slice discarded.
    applyStimulus(2, 25'h0000001, 25'h0000001);
    applyStimulus(2, 25'h0000002, 25'h0000400);
    applyStimulus(2, 25'h0000020, 25'h0010000);
    repeat (3) step();
    outReady[2] = 1'b0;
    applyStimulus(2, 25'h0000018, 25'h0008020);
    checkOutput("pre_clear_page", 2, 32'(pageIdx[2]), 32'd3);
    outReady[2] = 1'b1;
    clear[2]    = 1'b1;
    step();
    clear[2] = 1'b0;
    expQ[2].delete();
    expPage[2] = 0;
    checkIdle(2);
    checkOutput("clear_out_data_kept", 2, 32'(outData[2]), 32'h0008020);
    step();
    checkOutput("clear_no_frame_done", 2, 32'(frameDone[2]), 32'd0);
    applyStimulus(2, 25'h1000000, 25'h0000010);
    repeat (5) step();

    for (int g = 0; g < 3; g++) begin
      checks++;
      if (expQ[g].size() != 0) begin
        errors++;
        $display("[TB] FAIL drain lane %0d actual=%0d required=0", g, expQ[g].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
